// File: rtl/seqdet_pkg.sv
// Shared definitions for the bit-serial sequence detectors and their serial feeder.
package seqdet_pkg;

  typedef logic [0:0] feeder_state_t;

  localparam feeder_state_t IDLE  = 1'b0;
  localparam feeder_state_t SHIFT = 1'b1;

  localparam logic SEQDET_IDLE_BIT = 1'b0;

endpackage

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: first bit on x the cycle after accept, WIDTH cycles per word.
// in_ready drops only while the one-entry holding register is full; x has no backpressure.
module serial_bit_feeder
  import seqdet_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = SEQDET_IDLE_BIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic [15:0]      words_sent
);

  localparam logic [4:0] LAST_CNT = 5'(WIDTH - 1);

  feeder_state_t    state;
  logic [WIDTH-1:0] shift_dat;
  logic [WIDTH-1:0] hold_dat;
  logic [WIDTH-1:0] shift_next;
  logic             hold_full;
  logic [4:0]       bit_cnt;
  logic             accept;
  logic             last_bit;
  logic             out_bit;

  assign in_ready = !hold_full;
  assign accept   = in_valid && in_ready;
  assign last_bit = (state == SHIFT) && (bit_cnt == LAST_CNT);

  // The output end of the shifter is fixed by bit order; data moves toward it.
  generate
    if (MSB_FIRST) begin : g_msb
      assign shift_next = {shift_dat[WIDTH-2:0], 1'b0};
      assign out_bit    = shift_dat[WIDTH-1];
    end else begin : g_lsb
      assign shift_next = {1'b0, shift_dat[WIDTH-1:1]};
      assign out_bit    = shift_dat[0];
    end
  endgenerate

  assign x_valid = (state == SHIFT);
  assign x       = (state == SHIFT) ? out_bit : IDLE_BIT;
  assign busy    = (state == SHIFT) || hold_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      shift_dat  <= '0;
      hold_dat   <= '0;
      hold_full  <= 1'b0;
      bit_cnt    <= '0;
      words_sent <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shift_dat <= in_data;
            bit_cnt   <= '0;
            state     <= SHIFT;
          end
        end
        default: begin
          if (last_bit) begin
            words_sent <= words_sent + 16'd1;
            bit_cnt    <= '0;
            // A held word wins over a new offer; in_ready is low then anyway.
            if (hold_full) begin
              shift_dat <= hold_dat;
              hold_full <= 1'b0;
            end else if (accept) begin
              shift_dat <= in_data;
            end else begin
              state <= IDLE;
            end
          end else begin
            shift_dat <= shift_next;
            bit_cnt   <= bit_cnt + 5'd1;
            if (accept) begin
              hold_dat  <= in_data;
              hold_full <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule
